// File: rtl/sha_pkg.sv
// Shared widths and initial hash values for the SHA-256 block buffer.
// Bit 255 of each IV holds the most significant bit of H0.
package sha_pkg;

    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned HASH_W  = 256;

    localparam logic [HASH_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [HASH_W-1:0] SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

endpackage

// File: rtl/sha_hash_reg.sv
// Chaining-hash register: holds prev_hash, reloads an IV on reset_hash,
// and captures the round core's result on sample_hash.
module sha_hash_reg
    import sha_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_reset_hash,
    input  logic              i_sample_hash,
    input  logic              i_mode_224,
    input  logic [HASH_W-1:0] i_hash_in,
    output logic [HASH_W-1:0] o_prev_hash
);

    logic [HASH_W-1:0] r_hash;

    // reset_hash outranks sample_hash when both are asserted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hash <= SHA256_IV;
        end else if (i_reset_hash) begin
            r_hash <= i_mode_224 ? SHA224_IV : SHA256_IV;
        end else if (i_sample_hash) begin
            r_hash <= i_hash_in;
        end
    end

    assign o_prev_hash = r_hash;

endmodule

// File: rtl/sha_block_buffer.sv
// Packs IN_W-bit words into 512-bit message blocks. One or two banks let the
// next block fill while the round core consumes the current one.
module sha_block_buffer
    import sha_pkg::*;
#(
    parameter  int unsigned IN_W      = 64,
    parameter  int unsigned NUM_BANKS = 2,
    localparam int unsigned WORDS     = BLOCK_W / IN_W,
    localparam int unsigned FILL_W    = $clog2(WORDS + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [IN_W-1:0]    i_in_data,
    output logic               o_blk_valid,
    input  logic               i_blk_ready,
    output logic [BLOCK_W-1:0] o_blk_data,
    output logic [FILL_W-1:0]  o_fill_level,
    input  logic               i_clear,
    input  logic [HASH_W-1:0]  i_hash_in,
    input  logic               i_sample_hash,
    input  logic               i_reset_hash,
    input  logic               i_mode_224,
    output logic [HASH_W-1:0]  o_prev_hash
);

    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (!(IN_W == 32 || IN_W == 64 || IN_W == 128 || IN_W == 256 || IN_W == 512))
    begin : g_bad_in_w
        $error("sha_block_buffer: IN_W must be one of 32, 64, 128, 256, 512");
    end
    if (!(NUM_BANKS == 1 || NUM_BANKS == 2)) begin : g_bad_banks
        $error("sha_block_buffer: NUM_BANKS must be 1 or 2");
    end

    logic [BLOCK_W-1:0]   r_bank [NUM_BANKS];
    logic [NUM_BANKS-1:0] r_full;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;

    logic       w_wr_ptr_nxt;
    logic       w_rd_ptr_nxt;
    logic       w_in_ready;
    logic       w_wr_fire;
    logic       w_rd_fire;
    logic       w_last;
    logic [8:0] w_msb;

    if (NUM_BANKS == 2) begin : g_ping_pong
        assign w_wr_ptr_nxt = ~r_wr_ptr;
        assign w_rd_ptr_nxt = ~r_rd_ptr;
    end else begin : g_single
        assign w_wr_ptr_nxt = 1'b0;
        assign w_rd_ptr_nxt = 1'b0;
    end

    // in_ready depends only on registered flags, never on blk_ready
    assign w_in_ready = ~r_full[r_wr_ptr];
    assign w_wr_fire  = i_in_valid & w_in_ready;
    assign w_rd_fire  = r_full[r_rd_ptr] & i_blk_ready;
    assign w_last     = (r_cnt == CNT_W'(WORDS - 1));
    assign w_msb      = 9'(BLOCK_W - 1 - 32'(r_cnt) * IN_W);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_bank[b] <= '0;
            end
            r_full   <= '0;
            r_cnt    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            // a write only targets a non-full bank and a release only a full one,
            // so both may land in the same cycle without touching the same flag
            if (w_rd_fire) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= w_rd_ptr_nxt;
            end
            if (w_wr_fire) begin
                r_bank[r_wr_ptr][w_msb -: IN_W] <= i_in_data;
                if (w_last) begin
                    r_full[r_wr_ptr] <= 1'b1;
                    r_cnt            <= '0;
                    r_wr_ptr         <= w_wr_ptr_nxt;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_blk_valid  = r_full[r_rd_ptr];
    assign o_blk_data   = r_bank[r_rd_ptr];
    assign o_fill_level = r_full[r_wr_ptr] ? FILL_W'(WORDS) : FILL_W'(r_cnt);

    sha_hash_reg u_hash_reg (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_reset_hash (i_reset_hash),
        .i_sample_hash(i_sample_hash),
        .i_mode_224   (i_mode_224),
        .i_hash_in    (i_hash_in),
        .o_prev_hash  (o_prev_hash)
    );

endmodule

// File: tb/tb_sha_block_buffer.sv
// Drives a 64-bit/two-bank and a 32-bit/one-bank buffer with the same control
// stream and compares both against a block-queue reference model.
module tb_sha_block_buffer;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    logic         clk = 1'b0;
    logic         rst, in_valid, blk_ready, clear, sample_hash, reset_hash, mode_224;
    logic [63:0]  in_data;
    logic [255:0] hash_in;

    logic         rdy0, vld0, rdy1, vld1;
    logic [511:0] blk0, blk1;
    logic [3:0]   fill0;
    logic [4:0]   fill1;
    logic [255:0] ph0, ph1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sha_block_buffer #(.IN_W(64), .NUM_BANKS(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy0),
        .i_in_data(in_data), .o_blk_valid(vld0), .i_blk_ready(blk_ready),
        .o_blk_data(blk0), .o_fill_level(fill0), .i_clear(clear), .i_hash_in(hash_in),
        .i_sample_hash(sample_hash), .i_reset_hash(reset_hash), .i_mode_224(mode_224),
        .o_prev_hash(ph0)
    );

    sha_block_buffer #(.IN_W(32), .NUM_BANKS(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy1),
        .i_in_data(in_data[31:0]), .o_blk_valid(vld1), .i_blk_ready(blk_ready),
        .o_blk_data(blk1), .o_fill_level(fill1), .i_clear(clear), .i_hash_in(hash_in),
        .i_sample_hash(sample_hash), .i_reset_hash(reset_hash), .i_mode_224(mode_224),
        .o_prev_hash(ph1)
    );

    // Reference model: completed blocks wait in a queue holding at most nb blocks;
    // the block being assembled is kept apart with its word count.
    int           m_words [2] = '{8, 16};
    int           m_nb    [2] = '{2, 1};
    int           m_inw   [2] = '{64, 32};
    logic [511:0] m_pend  [2][$];
    logic [511:0] m_part  [2];
    int           m_cnt   [2];
    logic [255:0] m_hash;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic v, input logic [63:0] d, input logic br,
                                input logic clr, input logic r, input logic sh,
                                input logic rh, input logic m, input logic [255:0] hin);
        for (int i = 0; i < 2; i++) begin
            if (r || clr) begin
                m_pend[i].delete();
                m_part[i] = '0;
                m_cnt[i]  = 0;
            end else begin
                bit acc, rel;
                logic [511:0] wv;
                acc = v && (m_pend[i].size() < m_nb[i]);
                rel = br && (m_pend[i].size() > 0);
                if (rel) void'(m_pend[i].pop_front());
                if (acc) begin
                    wv = (i == 0) ? {448'b0, d} : {480'b0, d[31:0]};
                    m_part[i] = m_part[i] | (wv << (512 - (m_cnt[i] + 1) * m_inw[i]));
                    m_cnt[i]++;
                    if (m_cnt[i] == m_words[i]) begin
                        m_pend[i].push_back(m_part[i]);
                        m_part[i] = '0;
                        m_cnt[i]  = 0;
                    end
                end
            end
        end
        if (r)       m_hash = IV256;
        else if (rh) m_hash = m ? IV224 : IV256;
        else if (sh) m_hash = hin;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit full_all;
            full_all = (m_pend[i].size() == m_nb[i]);
            check_eq($sformatf("in_ready[%0d]", i), (i == 0) ? rdy0 : rdy1, !full_all);
            check_eq($sformatf("blk_valid[%0d]", i), (i == 0) ? vld0 : vld1,
                     m_pend[i].size() > 0);
            check_eq($sformatf("fill_level[%0d]", i), (i == 0) ? 5'(fill0) : fill1,
                     full_all ? m_words[i] : m_cnt[i]);
            check_eq($sformatf("prev_hash[%0d]", i), (i == 0) ? ph0 : ph1, m_hash);
            if (m_pend[i].size() > 0)
                check_eq($sformatf("blk_data[%0d]", i), (i == 0) ? blk0 : blk1, m_pend[i][0]);
        end
    endtask

    // Called at a falling edge: drive, advance the model, then check after the rising edge.
    task automatic step(input logic v, input logic [63:0] d, input logic br, input logic clr,
                        input logic r, input logic sh, input logic rh, input logic m,
                        input logic [255:0] hin);
        in_valid = v; in_data = d; blk_ready = br; clear = clr; rst = r;
        sample_hash = sh; reset_hash = rh; mode_224 = m; hash_in = hin;
        model_update(v, d, br, clr, r, sh, rh, m, hin);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 64'h0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic words(input int n, input logic br);
        for (int k = 0; k < n; k++)
            step(1, {$urandom, $urandom}, br, 0, 0, 0, 0, 0, '0);
    endtask

    logic [63:0]  t1w [8] = '{64'hABCDEF01ABCDEF01, 64'h0123456789ABCDEF,
                              64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D,
                              64'h0F1E2D3C4B5A6978, 64'h1122334455667788,
                              64'h99AABBCCDDEEFF00, 64'hADDBAD00BADBABDA};
    logic [511:0] t1_blk;
    logic [255:0] hpat;

    initial begin
        in_valid = 0; in_data = '0; blk_ready = 0; clear = 0; rst = 1;
        sample_hash = 0; reset_hash = 0; mode_224 = 0; hash_in = '0;
        m_hash = '0;
        @(negedge clk);
        step(0, 64'h0, 0, 0, 1, 0, 0, 0, '0);
        step(0, 64'h0, 0, 0, 1, 0, 0, 0, '0);
        check_eq("reset_blk_data0", blk0, '0);
        check_eq("reset_blk_data1", blk1, '0);
        check_eq("reset_prev_hash", ph0, IV256);

        // one full 64-bit block, then held while not taken
        for (int k = 0; k < 8; k++) step(1, t1w[k], 0, 0, 0, 0, 0, 0, '0);
        t1_blk = '0;
        for (int k = 0; k < 8; k++) t1_blk = {t1_blk[447:0], t1w[k]};
        check_eq("t1_blk_data", blk0, t1_blk);
        check_eq("t1_blk_valid", vld0, 1'b1);
        check_eq("t1_fill_next_bank", fill0, 4'd0);
        idle(5);
        check_eq("t1_blk_stable", blk0, t1_blk);

        // second block with a gap, both banks full, then one release
        words(2, 0);
        idle(4);
        words(6, 0);
        check_eq("t2_in_ready_full", rdy0, 1'b0);
        step(0, 64'h0, 1, 0, 0, 0, 0, 0, '0);
        check_eq("t2_in_ready_restored", rdy0, 1'b1);
        idle(2);

        // last word of a block lands in the same cycle as a release
        words(7, 0);
        step(1, {$urandom, $urandom}, 1, 0, 0, 0, 0, 0, '0);
        idle(2);
        words(16, 1);

        // clear wins over a same-cycle input word
        step(0, 64'h0, 1, 1, 0, 0, 0, 0, '0);
        words(3, 0);
        step(1, {$urandom, $urandom}, 0, 1, 0, 0, 0, 0, '0);
        check_eq("t4_fill_after_clear", fill0, 4'd0);
        check_eq("t4_valid_after_clear", vld0, 1'b0);
        words(8, 0);

        // hash register
        hpat = {32'hAAAAAAAA, 32'h99999999, 32'h88888888, 32'h77777777,
                32'h66666666, 32'h55555555, 32'h44444444, 32'h11111111};
        step(0, 64'h0, 0, 0, 0, 1, 0, 0, hpat);
        check_eq("t5_sample", ph0, hpat);
        step(0, 64'h0, 0, 0, 0, 1, 1, 1, hpat);
        check_eq("t5_iv224", ph1, IV224);
        step(0, 64'h0, 0, 0, 0, 1, 1, 0, hpat);
        check_eq("t5_iv256", ph0, IV256);

        // reset mid-block and with both banks full
        step(0, 64'h0, 0, 1, 0, 0, 0, 0, '0);
        words(5, 0);
        step(1, {$urandom, $urandom}, 1, 0, 1, 1, 0, 0, hpat);
        check_eq("t6_fill_mid", fill0, 4'd0);
        words(16, 0);
        step(1, {$urandom, $urandom}, 1, 1, 1, 0, 0, 0, '0);
        check_eq("t6_blk_data", blk0, '0);
        check_eq("t6_in_ready", rdy1, 1'b1);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [255:0] h;
            for (int j = 0; j < 8; j++) h[j*32 +: 32] = $urandom;
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)), h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
